// File: rtl/instr_seq_decode.sv
// instr_seq_decode: fetch/execute sequencer and one-hot opcode decoder for the
// 8-bit CPU. Drives the phase bit (sm), the decode strobes, the greater-than
// flag g and the sticky illegal-opcode flag consumed by con_signal.
//
// Optional feature: define SINGLE_STEP_EN to add the 'step' input and the
// STEP_WAIT state. After each instruction the sequencer then parks in
// STEP_WAIT until it sees a rising edge on 'step'.
//
// Handshake/timing contract: there is no valid/ready pair. sm_en is a plain
// enable; when it is 0 on a rising clock edge, state, g and illegal hold.
// Strobes are combinational from ir[7:4], gated by the registered state, so
// they are valid for the whole EXEC cycle and drop as soon as rst rises.
//
// o_dbg_state exposes the sequencer state for observation:
//   0 = FETCH, 1 = EXEC, 2 = HALTED, 3 = STEP_WAIT (single-step builds only).
module instr_seq_decode #(
    parameter logic [3:0] HALT_OP      = 4'hF,
    parameter bit         ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic       sm_en,
    input  logic       alu_gt,
    input  logic       gf_en,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       sm,
    output logic       mova,
    output logic       movb,
    output logic       movc,
    output logic       movd,
    output logic       movi,
    output logic       add,
    output logic       sub,
    output logic       jmp,
    output logic       jg,
    output logic       in1,
    output logic       out1,
    output logic       halt,
    output logic       g,
    output logic       illegal,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_EXEC      = 2'd1,
        S_HALTED    = 2'd2
`ifdef SINGLE_STEP_EN
        ,
        S_STEP_WAIT = 2'd3
`endif
    } state_t;

    // Bit positions inside the non-halt decode vector, one per opcode value.
    localparam int D_MOVA = 0;
    localparam int D_MOVB = 1;
    localparam int D_MOVC = 2;
    localparam int D_MOVD = 3;
    localparam int D_MOVI = 4;
    localparam int D_JMP  = 5;
    localparam int D_JG   = 6;
    localparam int D_IN1  = 7;
    localparam int D_OUT1 = 8;
    localparam int D_ADD  = 9;
    localparam int D_SUB  = 10;

    state_t      r_state;
    logic        r_sm;
    logic        r_g;
    logic        r_illegal;

    logic [3:0]  w_op;
    logic        w_is_halt;
    logic        w_undef;
    logic [10:0] w_dec;
    logic        w_exec;
    logic        w_halted;
    logic        w_step_rise;
    logic        w_unused_operand;

    assign w_op = ir[7:4];

    // The low nibble is the operand; the datapath uses it, this block does not.
    assign w_unused_operand = ^ir[3:0];

    // Opcode decode; the halt opcode is checked first so it wins any collision.
    always_comb begin
        w_dec     = '0;
        w_is_halt = (w_op == HALT_OP);
        w_undef   = 1'b0;
        if (!w_is_halt) begin
            case (w_op)
                4'h0:    w_dec[D_MOVA] = 1'b1;
                4'h1:    w_dec[D_MOVB] = 1'b1;
                4'h2:    w_dec[D_MOVC] = 1'b1;
                4'h3:    w_dec[D_MOVD] = 1'b1;
                4'h4:    w_dec[D_MOVI] = 1'b1;
                4'h5:    w_dec[D_JMP]  = 1'b1;
                4'h6:    w_dec[D_JG]   = 1'b1;
                4'h7:    w_dec[D_IN1]  = 1'b1;
                4'h8:    w_dec[D_OUT1] = 1'b1;
                4'h9:    w_dec[D_ADD]  = 1'b1;
                4'hA:    w_dec[D_SUB]  = 1'b1;
                default: w_undef       = 1'b1;
            endcase
        end
    end

    assign w_exec   = (r_state == S_EXEC);
    assign w_halted = (r_state == S_HALTED);

    assign mova = w_exec & w_dec[D_MOVA];
    assign movb = w_exec & w_dec[D_MOVB];
    assign movc = w_exec & w_dec[D_MOVC];
    assign movd = w_exec & w_dec[D_MOVD];
    assign movi = w_exec & w_dec[D_MOVI];
    assign jmp  = w_exec & w_dec[D_JMP];
    assign jg   = w_exec & w_dec[D_JG];
    assign in1  = w_exec & w_dec[D_IN1];
    assign out1 = w_exec & w_dec[D_OUT1];
    assign add  = w_exec & w_dec[D_ADD];
    assign sub  = w_exec & w_dec[D_SUB];
    assign halt = (w_exec & w_is_halt) | w_halted;

    assign sm          = r_sm;
    assign g           = r_g;
    assign illegal     = r_illegal;
    assign o_dbg_state = r_state;

`ifdef SINGLE_STEP_EN
    logic r_step_d;

    // Registered copy of step so a long step pulse advances only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step;
        end
    end

    assign w_step_rise = step & ~r_step_d;
`else
    assign w_step_rise = 1'b0;
`endif

    // Sequencer: FETCH -> EXEC -> (STEP_WAIT ->) FETCH, or EXEC -> HALTED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_sm    <= 1'b0;
        end else if (sm_en) begin
            case (r_state)
                S_FETCH: begin
                    r_state <= S_EXEC;
                    r_sm    <= 1'b1;
                end
                S_EXEC: begin
                    if (w_is_halt || (w_undef && ILLEGAL_HALT)) begin
                        r_state <= S_HALTED;
                        r_sm    <= 1'b1;
                    end else begin
`ifdef SINGLE_STEP_EN
                        r_state <= S_STEP_WAIT;
`else
                        r_state <= S_FETCH;
`endif
                        r_sm    <= 1'b0;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                    r_sm    <= 1'b1;
                end
`ifdef SINGLE_STEP_EN
                S_STEP_WAIT: begin
                    if (w_step_rise) begin
                        r_state <= S_FETCH;
                    end
                    r_sm <= 1'b0;
                end
`endif
                default: begin
                    r_state <= S_FETCH;
                    r_sm    <= 1'b0;
                end
            endcase
        end
    end

    // Flags: g captures alu_gt when enabled; illegal latches an undefined EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g       <= 1'b0;
            r_illegal <= 1'b0;
        end else if (sm_en) begin
            if (gf_en) begin
                r_g <= alu_gt;
            end
            if (w_exec && w_undef) begin
                r_illegal <= 1'b1;
            end
        end
    end

endmodule
